reg_file_arbiter: RTL and testbench
===================================

# reg_file_arbiter

Two-port access arbiter and sequencer for the system register file (ADDR_WIDTH-bit address, REG_WIDTH-bit registers). It lets two masters share the file's single read/write port: the system controller on port 0 and the configuration/debug path on port 1. Per-operation request/grant uses round-robin priority. The block drives the file's RdEn/WrEn/Address/WrData strobes and routes the returned read data to the requester that owns it, with a timeout guard.

## Interface
- ADDR_WIDTH, 4, register file address width
- REG_WIDTH, 8, register data width
- RD_TIMEOUT, 4, cycles to wait for read valid before flagging error (≥1)

- i_CLK  in  1  single clock; all flops rising-edge
- i_RST  in  1  reset; asynchronous, active-high
- i_Req_0 / i_Req_1  in  1  access request, held until granted
- i_Wr_0 / i_Wr_1  in  1  1 = write, 0 = read; stable while Req high
- i_Address_0 / i_Address_1  in  ADDR_WIDTH  target register
- i_WrData_0 / i_WrData_1  in  REG_WIDTH  write data
- o_Gnt_0 / o_Gnt_1  out  1  one-cycle grant pulse; command accepted
- o_RdData_0 / o_RdData_1  out  REG_WIDTH  read data, held until next read for that port
- o_RdData_Valid_0 / o_RdData_Valid_1  out  1  one-cycle read-data pulse
- o_Err_0 / o_Err_1  out  1  one-cycle read-timeout pulse
- o_RF_RdEn, o_RF_WrEn  out  1  register file strobes
- o_RF_Address  out  ADDR_WIDTH;  o_RF_WrData  out  REG_WIDTH
- i_RF_RdData  in  REG_WIDTH;  i_RF_RdData_Valid  in  1  file read return

## Operation
- FSM states: IDLE, WRITE, READ, WAIT_RD. Encoding 2-bit binary.
- IDLE: if any Req is high, arbitrate, latch the winner's ID, Wr, Address and WrData, then go to WRITE (Wr=1) or READ (Wr=0). Otherwise stay in IDLE.
- WRITE: o_RF_WrEn=1, o_Gnt_winner=1; next IDLE.
- READ: o_RF_RdEn=1, o_Gnt_winner=1; clear the timeout counter; next WAIT_RD.
- WAIT_RD:
  - On i_RF_RdData_Valid: capture i_RF_RdData into o_RdData_winner, pulse o_RdData_Valid_winner, go to IDLE.
  - Otherwise increment the counter. When the counter reaches RD_TIMEOUT, pulse o_Err_winner and go to IDLE.
- Arbitration:
  - A single requester wins.
  - If both request, the port holding priority wins. Priority passes to the other port after every grant.
  - Priority resets to port 0.
- Requests are sampled only in IDLE. Req high in any other state has no effect.
- o_RF_Address/o_RF_WrData hold the latched command values. They return to 0 in IDLE.
- All outputs are registered.
- i_RF_RdData_Valid outside WAIT_RD is ignored: no output pulse, no data update.
- Reset (asynchronous, any time):
  - State goes to IDLE, priority to port 0, counter to 0.
  - Every output goes to 0, including o_RdData_x.
  - An in-flight read is abandoned and never reports Valid or Err.

## Timing
- Requests sampled in IDLE at edge N cause Gnt and the RF strobe to be high from N to N+1.
- A write is committed by the file at edge N+1. The arbiter is back in IDLE at N+1 and can sample a new request at N+2, giving a write throughput of 1 per 2 cycles.
- For a read with file valid one cycle after RdEn, o_RdData_Valid_x is high from N+2 to N+3. Read-to-read spacing is 3 cycles.
- The timeout Err pulse occurs RD_TIMEOUT+1 cycles after Gnt.
- The requester drops Req on the edge after seeing Gnt. A Req still high at the next IDLE sample is treated as a new request.
- Gnt_0 and Gnt_1 are never high together. The same holds for Valid and Err across ports.

## Structure
- Shared package reg_file_arb_pkg:
  - State localparams IDLE=2'd0, WRITE=2'd1, READ=2'd2, WAIT_RD=2'd3.
  - Port IDs PORT0=1'b0, PORT1=1'b1.
  - Default widths.
- Sub-module rr_arbiter_2: two requests in; one-hot grant out. It holds the priority flop and updates it on an advance strobe from the FSM.
- Top module: FSM, command latch, timeout counter, per-port output registers.

## Test plan
- Reset/idle: hold i_RST=1 → all outputs 0. Release with no Req → no strobe for 10 cycles.
- Port-0 write: Req_0=1, Wr_0=1, Addr=7, Data=100 → Gnt_0 and RF_WrEn high together for one cycle with Address=7, WrData=100. A following read of 7 on port 1 returns o_RdData_1=100 with Valid_1 2 cycles after Gnt_1.
- Round-robin contention: both ports request writes continuously (port 0 to addr 1 / data 15, port 1 to addr 10 / data 200) → grants alternate 0,1,0,1; no double grant. Addresses on the RF match the granted port.
- Read routing: port 1 reads addr 2 while port 0 is idle → only Valid_1 pulses and o_RdData_0 is unchanged. A spurious RF valid in IDLE produces no pulse.
- Timeout: RF model never returns valid for a port-0 read → o_Err_0 pulses RD_TIMEOUT+1 (=5) cycles after Gnt_0, and the FSM returns to IDLE and serves a pending port-1 request.
- Reset mid-read: assert i_RST in WAIT_RD → outputs clear immediately. The RF valid arriving after release is ignored, and the next request is granted to port 0 first.

Source files
------------

// File: rtl/reg_file_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
package reg_file_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_REG_WIDTH  = 8;
  localparam int DEF_RD_TIMEOUT = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t WRITE   = 2'd1;
  localparam state_t READ    = 2'd2;
  localparam state_t WAIT_RD = 2'd3;

  typedef logic port_id_t;
  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  function automatic logic [1:0] port_onehot(input port_id_t id);
    return (id == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority flop
// hands priority to the other port whenever the advance strobe fires.
module rr_arbiter_2
  import reg_file_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  port_id_t prio;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || prio == PORT0)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PORT0;
    end else if (adv) begin
      prio <= gnt[0] ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares the register file's single port between two masters; sequences
// write/read strobes, routes read data back to its owner, flags read timeouts.
module reg_file_arbiter
  import reg_file_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Req_0,
  input  logic                  i_Req_1,
  input  logic                  i_Wr_0,
  input  logic                  i_Wr_1,
  input  logic [ADDR_WIDTH-1:0] i_Address_0,
  input  logic [ADDR_WIDTH-1:0] i_Address_1,
  input  logic [REG_WIDTH-1:0]  i_WrData_0,
  input  logic [REG_WIDTH-1:0]  i_WrData_1,
  output logic                  o_Gnt_0,
  output logic                  o_Gnt_1,
  output logic [REG_WIDTH-1:0]  o_RdData_0,
  output logic [REG_WIDTH-1:0]  o_RdData_1,
  output logic                  o_RdData_Valid_0,
  output logic                  o_RdData_Valid_1,
  output logic                  o_Err_0,
  output logic                  o_Err_1,
  output logic                  o_RF_RdEn,
  output logic                  o_RF_WrEn,
  output logic [ADDR_WIDTH-1:0] o_RF_Address,
  output logic [REG_WIDTH-1:0]  o_RF_WrData,
  input  logic [REG_WIDTH-1:0]  i_RF_RdData,
  input  logic                  i_RF_RdData_Valid
);

  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_t                state, state_nxt;
  port_id_t              cmd_id, cmd_id_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [1:0]            arb_gnt;
  logic                  arb_adv;
  logic                  win_wr;
  logic [1:0]            gnt_nxt, vld_nxt, err_nxt;
  logic                  rden_nxt, wren_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [REG_WIDTH-1:0]  wdata_nxt, rdata0_nxt, rdata1_nxt;

  rr_arbiter_2 u_arb (
    .clk (i_CLK),
    .rst (i_RST),
    .req ({i_Req_1, i_Req_0}),
    .adv (arb_adv),
    .gnt (arb_gnt)
  );

  // Outputs are registered, so each one is computed for the state being entered.
  always_comb begin
    state_nxt  = state;
    cmd_id_nxt = cmd_id;
    cnt_nxt    = cnt;
    arb_adv    = 1'b0;
    win_wr     = 1'b0;
    gnt_nxt    = 2'b00;
    vld_nxt    = 2'b00;
    err_nxt    = 2'b00;
    rden_nxt   = 1'b0;
    wren_nxt   = 1'b0;
    addr_nxt   = o_RF_Address;
    wdata_nxt  = o_RF_WrData;
    rdata0_nxt = o_RdData_0;
    rdata1_nxt = o_RdData_1;

    case (state)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          arb_adv    = 1'b1;
          cmd_id_nxt = arb_gnt[1] ? PORT1 : PORT0;
          win_wr     = arb_gnt[1] ? i_Wr_1 : i_Wr_0;
          addr_nxt   = arb_gnt[1] ? i_Address_1 : i_Address_0;
          wdata_nxt  = arb_gnt[1] ? i_WrData_1 : i_WrData_0;
          gnt_nxt    = arb_gnt;
          if (win_wr) begin
            state_nxt = WRITE;
            wren_nxt  = 1'b1;
          end else begin
            state_nxt = READ;
            rden_nxt  = 1'b1;
          end
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      READ: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_RD;
      end
      WAIT_RD: begin
        // A return on the same edge as the timeout still counts as data.
        if (i_RF_RdData_Valid) begin
          vld_nxt[cmd_id] = 1'b1;
          if (cmd_id == PORT1) rdata1_nxt = i_RF_RdData;
          else                 rdata0_nxt = i_RF_RdData;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          err_nxt[cmd_id] = 1'b1;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state_nxt == IDLE) begin
      addr_nxt  = '0;
      wdata_nxt = '0;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state            <= IDLE;
      cmd_id           <= PORT0;
      cnt              <= '0;
      o_Gnt_0          <= 1'b0;
      o_Gnt_1          <= 1'b0;
      o_RdData_Valid_0 <= 1'b0;
      o_RdData_Valid_1 <= 1'b0;
      o_Err_0          <= 1'b0;
      o_Err_1          <= 1'b0;
      o_RF_RdEn        <= 1'b0;
      o_RF_WrEn        <= 1'b0;
      o_RF_Address     <= '0;
      o_RF_WrData      <= '0;
      o_RdData_0       <= '0;
      o_RdData_1       <= '0;
    end else begin
      state            <= state_nxt;
      cmd_id           <= cmd_id_nxt;
      cnt              <= cnt_nxt;
      o_Gnt_0          <= gnt_nxt[0];
      o_Gnt_1          <= gnt_nxt[1];
      o_RdData_Valid_0 <= vld_nxt[0];
      o_RdData_Valid_1 <= vld_nxt[1];
      o_Err_0          <= err_nxt[0];
      o_Err_1          <= err_nxt[1];
      o_RF_RdEn        <= rden_nxt;
      o_RF_WrEn        <= wren_nxt;
      o_RF_Address     <= addr_nxt;
      o_RF_WrData      <= wdata_nxt;
      o_RdData_0       <= rdata0_nxt;
      o_RdData_1       <= rdata1_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: transaction-level model of grant order, timing
// rules and register contents, with a behavioural register file attached.
module tb_reg_file_arbiter;

  localparam int AW = 4;
  localparam int RW = 8;
  localparam int RD_TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [RW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, vld0, vld1, err0, err1, rden, wren;
  logic [RW-1:0] rd0, rd1, rf_wdata;
  logic [AW-1:0] rf_addr;
  logic [RW-1:0] rf_rdata;
  logic          rf_rvld;

  logic [1:0] gnt_vec, vld_vec, err_vec;
  logic [35:0] all_out;
  assign gnt_vec = {gnt1, gnt0};
  assign vld_vec = {vld1, vld0};
  assign err_vec = {err1, err0};
  assign all_out = {gnt_vec, vld_vec, err_vec, rden, wren, rf_addr, rf_wdata, rd0, rd1};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int free_cyc = 0;
  logic m_prio = 1'b0;
  logic [RW-1:0] ref_mem [16];
  logic [RW-1:0] mem [16];
  int cmd_delay [2];

  // Register file: writes land on the strobe edge, reads return after a set delay (0 = never).
  int rf_delay_cfg = 0;
  int rf_left = 0;
  logic [AW-1:0] rf_raddr = '0;
  logic rf_vld = 1'b0, inj_vld = 1'b0;
  logic [RW-1:0] rf_data = '0, inj_data = '0;
  assign rf_rvld  = rf_vld | inj_vld;
  assign rf_rdata = inj_vld ? inj_data : rf_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rf_vld <= 1'b0;
    if (wren) mem[rf_addr] <= rf_wdata;
    if (rden) begin
      rf_left  = rf_delay_cfg;
      rf_raddr = rf_addr;
    end
    if (rf_left > 0) begin
      rf_left--;
      if (rf_left == 0) begin
        rf_vld  <= 1'b1;
        rf_data <= mem[rf_raddr];
      end
    end
  end

  reg_file_arbiter #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_Req_0(req0), .i_Req_1(req1), .i_Wr_0(wr0), .i_Wr_1(wr1),
    .i_Address_0(addr0), .i_Address_1(addr1), .i_WrData_0(wdata0), .i_WrData_1(wdata1),
    .o_Gnt_0(gnt0), .o_Gnt_1(gnt1), .o_RdData_0(rd0), .o_RdData_1(rd1),
    .o_RdData_Valid_0(vld0), .o_RdData_Valid_1(vld1), .o_Err_0(err0), .o_Err_1(err1),
    .o_RF_RdEn(rden), .o_RF_WrEn(wren), .o_RF_Address(rf_addr), .o_RF_WrData(rf_wdata),
    .i_RF_RdData(rf_rdata), .i_RF_RdData_Valid(rf_rvld)
  );

  function automatic logic [1:0] onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int p, input logic wr, input logic [AW-1:0] a,
                         input logic [RW-1:0] d, input int dly);
    if (p == 0) begin
      wr0 = wr; addr0 = a; wdata0 = d;
    end else begin
      wr1 = wr; addr1 = a; wdata1 = d;
    end
    cmd_delay[p] = dly;
  endtask

  task automatic wait_gnt();
    int w;
    w = 0;
    @(negedge clk);
    while (gnt_vec == 2'b00 && w < 12) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Raise the given requests and follow every resulting command to completion.
  task automatic serve(input logic [1:0] reqs);
    logic [1:0] pend;
    logic p, q, qwr, exp_v;
    logic [AW-1:0] qa;
    logic [RW-1:0] qd, old0, old1;
    int c0, g, r, d, e;
    pend = reqs;
    req0 = reqs[0];
    req1 = reqs[1];
    c0 = cyc;
    for (int it = 0; it < 4 && pend != 2'b00; it++) begin
      p = (pend == 2'b11) ? m_prio : pend[1];
      wait_gnt();
      chk("gnt_port", gnt_vec, onehot(p));
      if (gnt_vec == 2'b00) begin
        req0 = 1'b0;
        req1 = 1'b0;
        return;
      end
      e = (c0 + 1 > free_cyc) ? c0 + 1 : free_cyc;
      chk("gnt_cycle", cyc, e);
      g = cyc;
      q = gnt_vec[1];
      qwr = q ? wr1 : wr0;
      qa  = q ? addr1 : addr0;
      qd  = q ? wdata1 : wdata0;
      chk("rf_strobe", {wren, rden}, {qwr, !qwr});
      chk("rf_addr", rf_addr, qa);
      chk("rf_wdata", rf_wdata, qd);
      if (q) req1 = 1'b0; else req0 = 1'b0;
      pend[q] = 1'b0;
      m_prio = !q;
      if (qwr) begin
        ref_mem[qa] = qd;
        free_cyc = g + 2;
      end else begin
        d = cmd_delay[q];
        rf_delay_cfg = d;
        old0 = rd0;
        old1 = rd1;
        exp_v = (d != 0 && d <= RD_TIMEOUT);
        r = exp_v ? g + 1 + d : g + 1 + RD_TIMEOUT;
        while (cyc < r) begin
          @(negedge clk);
          if (cyc < r) chk("rd_quiet", {gnt_vec, vld_vec, err_vec}, 64'd0);
        end
        chk("rd_valid", vld_vec, exp_v ? onehot(q) : 2'b00);
        chk("rd_err", err_vec, exp_v ? 2'b00 : onehot(q));
        chk("rd_data_own", q ? rd1 : rd0, exp_v ? ref_mem[qa] : (q ? old1 : old0));
        chk("rd_data_other", q ? rd0 : rd1, q ? old0 : old1);
        free_cyc = r + 1;
      end
    end
  endtask

  int strobes, last, c_start;
  logic [RW-1:0] s0, s1;
  logic [1:0] rq;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'(i * 13 + 5);
      mem[i]     = 8'(i * 13 + 5);
    end
    cmd_delay[0] = 1;
    cmd_delay[1] = 1;

    // Reset state, then an idle stretch with no requests.
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out, 64'd0);
    rst = 1'b0;
    strobes = 0;
    repeat (10) begin
      @(negedge clk);
      if (rden || wren || gnt_vec != 2'b00) strobes++;
    end
    chk("idle_quiet", strobes, 0);

    // Port-0 write followed by a port-1 read-back.
    set_cmd(0, 1'b1, 4'd7, 8'd100, 0);
    serve(2'b01);
    set_cmd(1, 1'b0, 4'd7, 8'd0, 1);
    serve(2'b10);
    chk("readback_100", rd1, 8'd100);

    // Continuous contention: grants must alternate every two cycles.
    set_cmd(0, 1'b1, 4'd1, 8'd15, 0);
    set_cmd(1, 1'b1, 4'd10, 8'd200, 0);
    req0 = 1'b1;
    req1 = 1'b1;
    c_start = cyc;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt();
      chk("rr_gnt", gnt_vec, onehot(m_prio));
      chk("rr_addr", rf_addr, gnt_vec[1] ? 4'd10 : 4'd1);
      chk("rr_wdata", rf_wdata, gnt_vec[1] ? 8'd200 : 8'd15);
      if (k == 0) chk("rr_first_cycle", cyc, (c_start + 1 > free_cyc) ? c_start + 1 : free_cyc);
      else        chk("rr_spacing", cyc, last + 2);
      last = cyc;
      ref_mem[gnt_vec[1] ? 10 : 1] = gnt_vec[1] ? 8'd200 : 8'd15;
      m_prio = !gnt_vec[1];
    end
    req0 = 1'b0;
    req1 = 1'b0;
    free_cyc = last + 2;

    // Port-1 read while port 0 is idle, then a spurious file valid in IDLE.
    set_cmd(1, 1'b0, 4'd2, 8'd0, 1);
    serve(2'b10);
    @(negedge clk);
    s0 = rd0;
    s1 = rd1;
    inj_data = 8'h5A;
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    chk("spurious_vld", {vld_vec, err_vec}, 64'd0);
    @(negedge clk);
    chk("spurious_data", {rd0, rd1}, {s0, s1});
    free_cyc = cyc + 1;

    // Port-0 read that never returns while port 1 waits.
    set_cmd(0, 1'b0, 4'd3, 8'd0, 0);
    set_cmd(1, 1'b0, 4'd10, 8'd0, 1);
    serve(2'b11);

    // Boundary: file answers exactly at the timeout edge.
    set_cmd(1, 1'b0, 4'd1, 8'd0, RD_TIMEOUT);
    serve(2'b10);

    // Randomized mix of reads, writes and contention.
    for (int i = 0; i < 40; i++) begin
      rq = 2'($urandom_range(1, 3));
      set_cmd(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
              int'($urandom_range(0, RD_TIMEOUT + 2)));
      set_cmd(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
              int'($urandom_range(0, RD_TIMEOUT + 2)));
      serve(rq);
    end

    // Reset in WAIT_RD: outputs clear at once, late return ignored, priority back to port 0.
    @(negedge clk);
    set_cmd(0, 1'b0, 4'd5, 8'd0, 3);
    req0 = 1'b1;
    wait_gnt();
    chk("rst_rd_gnt", gnt_vec, 2'b01);
    req0 = 1'b0;
    rf_delay_cfg = 3;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_clear", all_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_prio = 1'b0;
    free_cyc = 0;
    repeat (8) begin
      @(negedge clk);
      chk("rst_no_resp", {vld_vec, err_vec, rd0}, 64'd0);
    end
    set_cmd(0, 1'b1, 4'd3, 8'h3C, 0);
    set_cmd(1, 1'b1, 4'd4, 8'hC3, 0);
    serve(2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
